// File: rtl/brq_fetch_pkg.sv
// brq_fetch_pkg: shared types and constants for the Buraq-mini fetch stage
// Provides the fetch FSM state encoding, the buffered {pc, instr} entry and
// a helper giving the ICCM size in bytes for a given word-address width.
package brq_fetch_pkg;
   localparam int INSTR_W = 32;
   typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_e;
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;
   function automatic logic [32:0] iccm_bytes(input int aw);
      return 33'd4 << aw;
   endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch entries with flush
// Ports: brq_clk/brq_rst_n clock and async active-low reset; push/wdata write
// side; pop/rdata read side (rdata is zero when empty); flush empties the FIFO
// and overrides push/pop; full/empty status.
import brq_fetch_pkg::*;
module fetch_buffer #(
   parameter int Depth = 2
) (
   input  logic         brq_clk,
   input  logic         brq_rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output fetch_entry_t rdata,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(Depth);
   logic [PW:0]  wptr, rptr;
   fetch_entry_t mem [Depth];
   assign empty = wptr == rptr;
   assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   assign rdata = empty ? '0 : mem[rptr[PW-1:0]];
   always_ff @(posedge brq_clk or negedge brq_rst_n) begin
      if (!brq_rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wptr + {{PW{1'b0}}, push};
         rptr <= rptr + {{PW{1'b0}}, pop};
      end
   end
   always_ff @(posedge brq_clk) begin
      if (push && !flush) mem[wptr[PW-1:0]] <= wdata;
   end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: Buraq-mini fetch stage between the ICCM and decode
// Ports: brq_clk/brq_rst_n clock and async active-low reset; fetch_en run
// enable; iccm_addr/iccm_read/iccm_rdata ICCM word port (combinational read);
// redirect_valid/redirect_pc branch/jump/trap target; instr_valid/instr_ready
// handshake with instr_o/instr_pc_o head entry; fault_o/fault_pc_o sticky
// misaligned or out-of-range fetch fault.
import brq_fetch_pkg::*;
module instr_fetch #(
   parameter int          DataWidth = 32,
   parameter int          AddrWidth = 15,
   parameter logic [31:0] BootAddr  = 32'h0000_0000,
   parameter int          BufDepth  = 2
) (
   input  logic                 brq_clk,
   input  logic                 brq_rst_n,
   input  logic                 fetch_en,
   output logic [AddrWidth-1:0] iccm_addr,
   output logic                 iccm_read,
   input  logic [DataWidth-1:0] iccm_rdata,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [DataWidth-1:0] instr_o,
   output logic [31:0]          instr_pc_o,
   output logic                 fault_o,
   output logic [31:0]          fault_pc_o
);
   fetch_state_e state;
   logic [31:0]  pc;
   logic         pc_ok, pop, push, flush, full, empty;
   fetch_entry_t head;
   assign pc_ok       = (pc[1:0] == 2'b00) && ({1'b0, pc} < iccm_bytes(AddrWidth));
   assign instr_valid = !empty;
   assign pop         = instr_valid && instr_ready;
   // Read strobe depends only on state, pc and buffer space; a redirect
   // merely suppresses the push so it never reaches the ICCM port.
   assign iccm_read   = (state == FETCH) && pc_ok && (!full || pop);
   assign iccm_addr   = pc[AddrWidth+1:2];
   assign flush       = redirect_valid && (state != HALT);
   assign push        = iccm_read && !redirect_valid;
   assign instr_o     = head.instr;
   assign instr_pc_o  = head.pc;
   fetch_buffer #(.Depth(BufDepth)) u_buf (
      .brq_clk   (brq_clk),
      .brq_rst_n (brq_rst_n),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .wdata     ('{pc: pc, instr: iccm_rdata}),
      .rdata     (head),
      .full      (full),
      .empty     (empty)
   );
   always_ff @(posedge brq_clk or negedge brq_rst_n) begin
      if (!brq_rst_n) begin
         state      <= IDLE;
         pc         <= BootAddr;
         fault_o    <= 1'b0;
         fault_pc_o <= '0;
      end else if (state != HALT) begin
         state <= fetch_en ? FETCH : IDLE;
         if (redirect_valid) pc <= redirect_pc;
         else if (state == FETCH && !pc_ok) begin
            state      <= HALT;
            fault_o    <= 1'b1;
            fault_pc_o <= pc;
         end else if (push) pc <= pc + 32'd4;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a combinational ICCM model
import brq_fetch_pkg::*;
module tb_instr_fetch;
   logic        brq_clk = 1'b0;
   logic        brq_rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic [14:0] iccm_addr;
   logic        iccm_read;
   logic [31:0] iccm_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_o, instr_pc_o;
   logic        fault_o;
   logic [31:0] fault_pc_o;
   int compared = 0;
   int mismatched = 0;
   fetch_entry_t q[$];
   instr_fetch dut (
      .brq_clk(brq_clk), .brq_rst_n(brq_rst_n), .fetch_en(fetch_en),
      .iccm_addr(iccm_addr), .iccm_read(iccm_read), .iccm_rdata(iccm_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .fault_o(fault_o), .fault_pc_o(fault_pc_o)
   );
   always #5 brq_clk = ~brq_clk;
   function automatic logic [31:0] rom(input logic [14:0] a);
      return a == 15'd0 ? 32'h00500293 :
             a == 15'd1 ? 32'h00502A23 :
             a == 15'd2 ? 32'h005282B3 :
             a == 15'd3 ? 32'h01402283 : 32'hA5A5_0000 ^ {17'd0, a};
   endfunction
   assign iccm_rdata = rom(iccm_addr);
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask
   task automatic ex(input logic [31:0] pc);
      q.push_back('{pc: pc, instr: rom(pc[16:2])});
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge brq_clk);
         #1;
      end
   endtask
   task automatic do_reset();
      brq_rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      step(2);
      brq_rst_n = 1'b1;
   endtask
   always @(negedge brq_clk) begin
      if (brq_rst_n && instr_valid && instr_ready && !redirect_valid) begin
         if (q.size() == 0) chk("unexpected_pop_pc", instr_pc_o, 32'hFFFF_FFFF);
         else begin
            fetch_entry_t e;
            e = q.pop_front();
            chk("pop_pc", instr_pc_o, e.pc);
            chk("pop_instr", instr_o, e.instr);
         end
      end
   end
   initial begin
      // reset state
      step(2);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_read", {31'd0, iccm_read}, 32'd0);
      chk("rst_fault", {31'd0, fault_o}, 32'd0);
      chk("rst_fault_pc", fault_pc_o, 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", instr_pc_o, 32'd0);
      brq_rst_n = 1'b1;
      // streaming from boot
      ex(0); ex(4); ex(8); ex(12);
      fetch_en = 1'b1; instr_ready = 1'b1;
      chk("idle_read", {31'd0, iccm_read}, 32'd0);
      step(1);
      chk("c1_read", {31'd0, iccm_read}, 32'd1);
      chk("c1_valid", {31'd0, instr_valid}, 32'd0);
      step(1);
      chk("c2_valid", {31'd0, instr_valid}, 32'd1);
      chk("c2_pc", instr_pc_o, 32'd0);
      step(4);
      instr_ready = 1'b0;
      chk("s1_drain", q.size(), 32'd0);
      // backpressure until full
      do_reset();
      fetch_en = 1'b1;
      step(5);
      chk("full_read", {31'd0, iccm_read}, 32'd0);
      chk("full_addr", {17'd0, iccm_addr}, 32'd2);
      chk("full_valid", {31'd0, instr_valid}, 32'd1);
      chk("full_head", instr_pc_o, 32'd0);
      ex(0); ex(4); ex(8); ex(12);
      instr_ready = 1'b1;
      step(4);
      chk("pre_redir_head", instr_pc_o, 32'd16);
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      step(1);
      redirect_valid = 1'b0;
      chk("redir_flush", {31'd0, instr_valid}, 32'd0);
      chk("redir_read", {31'd0, iccm_read}, 32'd1);
      chk("redir_addr", {17'd0, iccm_addr}, 32'h10);
      ex(32'h40); ex(32'h44); ex(32'h48);
      step(4);
      instr_ready = 1'b0;
      chk("s2_drain", q.size(), 32'd0);
      // misaligned redirect faults on the next fetch attempt
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      step(1);
      redirect_valid = 1'b0;
      chk("mis_valid", {31'd0, instr_valid}, 32'd0);
      chk("mis_read", {31'd0, iccm_read}, 32'd0);
      chk("mis_fault_early", {31'd0, fault_o}, 32'd0);
      step(1);
      chk("mis_fault", {31'd0, fault_o}, 32'd1);
      chk("mis_fault_pc", fault_pc_o, 32'h42);
      chk("halt_read", {31'd0, iccm_read}, 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      step(1);
      redirect_valid = 1'b0;
      chk("halt_ignore_addr", {17'd0, iccm_addr}, 32'h10);
      chk("halt_ignore_read", {31'd0, iccm_read}, 32'd0);
      chk("halt_sticky", {31'd0, fault_o}, 32'd1);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      // run off the end of the ICCM
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'h0001_FFF0;
      fetch_en = 1'b1; instr_ready = 1'b1;
      ex(32'h0001_FFF0); ex(32'h0001_FFF4); ex(32'h0001_FFF8); ex(32'h0001_FFFC);
      step(1);
      redirect_valid = 1'b0;
      for (int i = 0; i < 20 && !fault_o; i++) step(1);
      chk("range_fault", {31'd0, fault_o}, 32'd1);
      chk("range_fault_pc", fault_pc_o, 32'h0002_0000);
      chk("range_drain", q.size(), 32'd0);
      // asynchronous reset mid-stream
      do_reset();
      fetch_en = 1'b1; instr_ready = 1'b1;
      ex(0); ex(4); ex(8);
      step(5);
      #2;
      brq_rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      chk("arst_read", {31'd0, iccm_read}, 32'd0);
      chk("arst_pc", instr_pc_o, 32'd0);
      chk("arst_instr", instr_o, 32'd0);
      chk("arst_drain", q.size(), 32'd0);
      step(1);
      brq_rst_n = 1'b1;
      ex(0); ex(4);
      step(1);
      chk("restart_read", {31'd0, iccm_read}, 32'd1);
      chk("restart_addr", {17'd0, iccm_addr}, 32'd0);
      step(1);
      chk("restart_valid", {31'd0, instr_valid}, 32'd1);
      chk("restart_pc", instr_pc_o, 32'd0);
      step(2);
      instr_ready = 1'b0; fetch_en = 1'b0;
      chk("restart_drain", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
